// File: rtl/urv_writeback_pkg.sv
// Shared types for the uRV writeback stage: FSM state encoding, load funct3 codes,
// the captured-load context and the regfile store-enable rule.
package urv_writeback_pkg;

    typedef enum logic [0:0] {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    // Everything about a load that must survive until the data returns.
    typedef struct packed {
        logic [4:0] rd;
        logic       rd_write;
        logic [2:0] fun;
        logic [1:0] addr;
    } wb_load_ctx_t;

    // x0 is hardwired to zero, so a write to it never strobes the regfile.
    function automatic logic rd_store_en(input logic rd_write, input logic [4:0] rd);
        return rd_write && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/urv_writeback_if.sv
// Execute/data-memory/regfile signal bundle around the writeback stage.
// master = surrounding pipeline, slave = urv_writeback.
interface urv_writeback_if;
    import urv_writeback_pkg::*;

    // Handshake: x_valid_i is a one-cycle pulse per instruction and is only
    // honoured in IDLE; w_stall_o is the inverse of ready, so execute must hold
    // bubbles while it is high. dm_load_done_i qualifies dm_data_l_i for one cycle.
    logic        x_valid_i;
    logic [4:0]  x_rd_i;
    logic [31:0] x_rd_value_i;
    logic        x_rd_write_i;
    logic        x_load_i;
    logic [2:0]  x_fun_i;
    logic [1:0]  x_dm_addr_i;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i;

    logic        w_stall_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_store_o;
    logic        rf_bypass_write_o;
    logic [31:0] rf_bypass_value_o;
    logic        w_load_fault_o;
    wb_state_t   wb_state;

    modport master (
        output x_valid_i, x_rd_i, x_rd_value_i, x_rd_write_i, x_load_i,
               x_fun_i, x_dm_addr_i, dm_data_l_i, dm_load_done_i,
        input  w_stall_o, rf_rd_o, rf_rd_value_o, rf_rd_store_o,
               rf_bypass_write_o, rf_bypass_value_o, w_load_fault_o, wb_state
    );

    modport slave (
        input  x_valid_i, x_rd_i, x_rd_value_i, x_rd_write_i, x_load_i,
               x_fun_i, x_dm_addr_i, dm_data_l_i, dm_load_done_i,
        output w_stall_o, rf_rd_o, rf_rd_value_o, rf_rd_store_o,
               rf_bypass_write_o, rf_bypass_value_o, w_load_fault_o, wb_state
    );

endinterface

// File: rtl/urv_writeback_load_align.sv
// urv_load_align: picks the addressed byte/halfword out of a load word and
// sign- or zero-extends it according to funct3; unknown codes behave as LW.
module urv_load_align
    import urv_writeback_pkg::*;
(
    input  logic [2:0]  fun_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd1:    byte_sel = data_i[15:8];
            2'd2:    byte_sel = data_i[23:16];
            2'd3:    byte_sel = data_i[31:24];
            default: byte_sel = data_i[7:0];
        endcase
    end

    assign half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        case (fun_i)
            LDST_B:  value_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_H:  value_o = {{16{half_sel[15]}}, half_sel};
            LDST_BU: value_o = {24'd0, byte_sel};
            LDST_HU: value_o = {16'd0, half_sel};
            LDST_L:  value_o = data_i;
            default: value_o = data_i;
        endcase
    end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback stage: registers ALU results, waits for load data, drives the regfile
// write port and W-stage bypass. Define URV_WB_LOAD_TIMEOUT_EN to abort hung loads.
module urv_writeback
    import urv_writeback_pkg::*;
#(
    parameter int unsigned g_load_timeout = 255
) (
    input logic            clk_i,
    input logic            rst_i,
    urv_writeback_if.slave wb
);

    if ((g_load_timeout == 0) || (g_load_timeout > 255)) begin : g_bad_timeout
        $error("urv_writeback: g_load_timeout must be within 1..255");
    end

    wb_state_t    state_q;
    wb_state_t    state_d;
    wb_load_ctx_t ctx_q;
    logic         capture;
    logic         timeout_hit;
    logic [31:0]  load_value;

    logic [4:0]   rd_q;
    logic [4:0]   rd_d;
    logic [31:0]  value_q;
    logic [31:0]  value_d;
    logic         store_q;
    logic         store_d;
    logic         stall;

    urv_load_align u_align (
        .fun_i   (ctx_q.fun),
        .addr_i  (ctx_q.addr),
        .data_i  (wb.dm_data_l_i),
        .value_o (load_value)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: begin
                if (wb.x_valid_i && wb.x_load_i) begin
                    state_d = WB_WAIT_LOAD;
                end
            end
            WB_WAIT_LOAD: begin
                if (wb.dm_load_done_i || timeout_hit) begin
                    state_d = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // rd/value default to holding; only the strobe returns to zero every idle cycle.
    always_comb begin
        capture = 1'b0;
        stall   = 1'b0;
        rd_d    = rd_q;
        value_d = value_q;
        store_d = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (wb.x_valid_i) begin
                    if (wb.x_load_i) begin
                        capture = 1'b1;
                    end else begin
                        rd_d    = wb.x_rd_i;
                        value_d = wb.x_rd_value_i;
                        store_d = rd_store_en(wb.x_rd_write_i, wb.x_rd_i);
                    end
                end
            end
            WB_WAIT_LOAD: begin
                stall = !wb.dm_load_done_i;
                if (wb.dm_load_done_i) begin
                    rd_d    = ctx_q.rd;
                    value_d = load_value;
                    store_d = rd_store_en(ctx_q.rd_write, ctx_q.rd);
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctx_q <= '0;
        end else if (capture) begin
            ctx_q <= '{rd:       wb.x_rd_i,
                       rd_write: wb.x_rd_write_i,
                       fun:      wb.x_fun_i,
                       addr:     wb.x_dm_addr_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q    <= '0;
            value_q <= '0;
            store_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            value_q <= value_d;
            store_q <= store_d;
        end
    end

`ifdef URV_WB_LOAD_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(g_load_timeout - 1);

    logic [7:0] tmo_cnt_q;
    logic       fault_q;

    // Expiry loses to a same-cycle done, so a late-but-valid load still writes.
    assign timeout_hit = (state_q == WB_WAIT_LOAD) && !wb.dm_load_done_i
                         && (tmo_cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            fault_q <= timeout_hit;
            if (state_q == WB_IDLE) begin
                tmo_cnt_q <= '0;
            end else if (!wb.dm_load_done_i) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
        end
    end

    assign wb.w_load_fault_o = fault_q;
`else
    assign timeout_hit       = 1'b0;
    assign wb.w_load_fault_o = 1'b0;
`endif

    assign wb.w_stall_o         = stall;
    assign wb.rf_rd_o           = rd_q;
    assign wb.rf_rd_value_o     = value_q;
    assign wb.rf_rd_store_o     = store_q;
    assign wb.rf_bypass_write_o = store_q;
    assign wb.rf_bypass_value_o = value_q;
    assign wb.wb_state          = state_q;

endmodule

// File: tb/tb_urv_writeback.sv
// Bench for urv_writeback: directed scenarios plus a randomized instruction stream
// checked against an arithmetic load model and an expected-write queue.
module tb_urv_writeback;
    import urv_writeback_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    // {store, rd, value} of each expected regfile write, in issue order
    logic [37:0] exp_q[$];
    logic [4:0]  m_rd;
    logic [31:0] m_val;

    urv_writeback_if bus ();

    urv_writeback #(.g_load_timeout(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.x_valid_i      = 1'b0;
        bus.x_rd_i         = '0;
        bus.x_rd_value_i   = '0;
        bus.x_rd_write_i   = 1'b0;
        bus.x_load_i       = 1'b0;
        bus.x_fun_i        = '0;
        bus.x_dm_addr_i    = '0;
        bus.dm_data_l_i    = '0;
        bus.dm_load_done_i = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val, input logic wr);
        bus.x_valid_i    = 1'b1;
        bus.x_load_i     = 1'b0;
        bus.x_rd_i       = rd;
        bus.x_rd_value_i = val;
        bus.x_rd_write_i = wr;
        tick();
        bus.x_valid_i    = 1'b0;
        m_rd  = rd;
        m_val = val;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic wr,
                              input logic [2:0] fun, input logic [1:0] addr);
        bus.x_valid_i    = 1'b1;
        bus.x_load_i     = 1'b1;
        bus.x_rd_i       = rd;
        bus.x_rd_value_i = $urandom;
        bus.x_rd_write_i = wr;
        bus.x_fun_i      = fun;
        bus.x_dm_addr_i  = addr;
        tick();
        bus.x_valid_i    = 1'b0;
        bus.x_load_i     = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [2:0] fun, input logic [1:0] addr,
                                               input logic [31:0] data);
        int unsigned b;
        int unsigned h;
        b = (data >> (8 * addr)) % 256;
        h = (data >> (16 * (addr / 2))) % 65536;
        case (fun)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return data;
        endcase
    endfunction

    function automatic logic [70:0] obs();
        return {bus.rf_rd_store_o, bus.rf_rd_o, bus.rf_rd_value_o,
                bus.rf_bypass_write_o, bus.rf_bypass_value_o};
    endfunction

    function automatic logic [70:0] expect_out(input logic st, input logic [4:0] rd,
                                               input logic [31:0] val);
        return {st, rd, val, st, val};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (obs() !== 71'd0 || bus.w_stall_o !== 1'b0 || bus.w_load_fault_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got out=%h stall=%b fault=%b, want all zero",
                     obs(), bus.w_stall_o, bus.w_load_fault_o);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== 71'd0 || bus.wb_state !== WB_IDLE) begin
            n_err++;
            $display("FAIL post_reset_idle: got out=%h state=%0d, want zero/IDLE", obs(), bus.wb_state);
        end
        m_rd  = '0;
        m_val = '0;
    endtask

    task automatic test_alu();
        drive_alu(5'd5, 32'hDEADBEEF, 1'b1);
        n_cmp++;
        if (obs() !== expect_out(1'b1, 5'd5, 32'hDEADBEEF)) begin
            n_err++;
            $display("FAIL alu_write: got %h want %h", obs(), expect_out(1'b1, 5'd5, 32'hDEADBEEF));
        end
        tick();
        n_cmp++;
        if (obs() !== expect_out(1'b0, 5'd5, 32'hDEADBEEF)) begin
            n_err++;
            $display("FAIL alu_strobe_drop: got %h want %h", obs(), expect_out(1'b0, 5'd5, 32'hDEADBEEF));
        end
        drive_alu(5'd0, 32'h0000_1234, 1'b1);
        n_cmp++;
        if (obs() !== expect_out(1'b0, 5'd0, 32'h0000_1234)) begin
            n_err++;
            $display("FAIL alu_x0: got %h want %h", obs(), expect_out(1'b0, 5'd0, 32'h0000_1234));
        end
        drive_alu(5'd7, 32'h0BAD_F00D, 1'b0);
        n_cmp++;
        if (obs() !== expect_out(1'b0, 5'd7, 32'h0BAD_F00D)) begin
            n_err++;
            $display("FAIL alu_no_write: got %h want %h", obs(), expect_out(1'b0, 5'd7, 32'h0BAD_F00D));
        end
    endtask

    task automatic test_load_align();
        logic [2:0]  funs [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  addrs[5] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
        logic [31:0] datas[5] = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_0000,
                                  32'h8001_0000, 32'h8001_0000};
        logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                  32'h0000_8001, 32'h8001_0000};
        int          waits[5] = '{3, 3, 1, 0, 2};
        for (int i = 0; i < 5; i++) begin
            drive_load(5'(10 + i), 1'b1, funs[i], addrs[i]);
            n_cmp++;
            if (bus.rf_rd_store_o !== 1'b0 || bus.wb_state !== WB_WAIT_LOAD) begin
                n_err++;
                $display("FAIL load_issue[%0d]: got store=%b state=%0d want 0/WAIT", i,
                         bus.rf_rd_store_o, bus.wb_state);
            end
            for (int w = 0; w < waits[i]; w++) begin
                bus.dm_data_l_i = $urandom;
                #1;
                n_cmp++;
                if (bus.w_stall_o !== 1'b1 || bus.rf_rd_store_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL load_stall[%0d] cycle %0d: got stall=%b store=%b want 1/0", i, w,
                             bus.w_stall_o, bus.rf_rd_store_o);
                end
                tick();
            end
            bus.dm_data_l_i    = datas[i];
            bus.dm_load_done_i = 1'b1;
            #1;
            n_cmp++;
            if (bus.w_stall_o !== 1'b0) begin
                n_err++;
                $display("FAIL load_done_stall[%0d]: got stall=%b want 0", i, bus.w_stall_o);
            end
            tick();
            bus.dm_load_done_i = 1'b0;
            n_cmp++;
            if (obs() !== expect_out(1'b1, 5'(10 + i), exps[i]) || bus.w_load_fault_o !== 1'b0) begin
                n_err++;
                $display("FAIL load_value[%0d]: got %h want %h", i, obs(),
                         expect_out(1'b1, 5'(10 + i), exps[i]));
            end
            m_rd  = 5'(10 + i);
            m_val = exps[i];
            tick();
        end
    endtask

    task automatic test_done_in_idle();
        bus.dm_data_l_i    = 32'hCAFE_0001;
        bus.dm_load_done_i = 1'b1;
        tick();
        bus.dm_load_done_i = 1'b0;
        n_cmp++;
        if (obs() !== expect_out(1'b0, m_rd, m_val) || bus.wb_state !== WB_IDLE) begin
            n_err++;
            $display("FAIL done_in_idle: got %h state=%0d want %h IDLE", obs(), bus.wb_state,
                     expect_out(1'b0, m_rd, m_val));
        end
    endtask

    task automatic test_random();
        logic [37:0] e;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        wr;
        logic [2:0]  fun;
        logic [1:0]  addr;
        int          waits;
        for (int n = 0; n < 80; n++) begin
            rd = 5'($urandom_range(0, 31));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                val = $urandom;
                exp_q.push_back({(wr && rd != 0), rd, val});
                drive_alu(rd, val, wr);
            end else begin
                fun   = 3'($urandom_range(0, 7));
                addr  = 2'($urandom_range(0, 3));
                val   = $urandom;
                waits = $urandom_range(0, 3);
                exp_q.push_back({(wr && rd != 0), rd, model_load(fun, addr, val)});
                drive_load(rd, wr, fun, addr);
                for (int w = 0; w < waits; w++) begin
                    // bubbles are not guaranteed here; a stray valid must be ignored
                    bus.x_valid_i   = 1'($urandom_range(0, 1));
                    bus.x_load_i    = 1'($urandom_range(0, 1));
                    bus.x_rd_i      = 5'($urandom_range(1, 31));
                    bus.x_rd_write_i = 1'b1;
                    bus.dm_data_l_i = $urandom;
                    #1;
                    n_cmp++;
                    if (bus.w_stall_o !== 1'b1 || bus.rf_rd_store_o !== 1'b0) begin
                        n_err++;
                        $display("FAIL rand_stall[%0d]: got stall=%b store=%b want 1/0", n,
                                 bus.w_stall_o, bus.rf_rd_store_o);
                    end
                    tick();
                end
                bus.x_valid_i      = 1'b0;
                bus.x_load_i       = 1'b0;
                bus.dm_data_l_i    = val;
                bus.dm_load_done_i = 1'b1;
                tick();
                bus.dm_load_done_i = 1'b0;
                m_rd  = rd;
                m_val = model_load(fun, addr, val);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== expect_out(e[37], e[36:32], e[31:0])) begin
                n_err++;
                $display("FAIL rand_write[%0d]: got %h want %h", n, obs(),
                         expect_out(e[37], e[36:32], e[31:0]));
            end
            if ($urandom_range(0, 2) == 0) begin
                tick();
                n_cmp++;
                if (obs() !== expect_out(1'b0, m_rd, m_val) || bus.w_stall_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_hold[%0d]: got %h want %h", n, obs(),
                             expect_out(1'b0, m_rd, m_val));
                end
            end
        end
    endtask

    task automatic test_timeout();
        drive_load(5'd20, 1'b1, 3'b010, 2'd0);
`ifdef URV_WB_LOAD_TIMEOUT_EN
        for (int w = 0; w < 4; w++) begin
            n_cmp++;
            if (bus.w_stall_o !== 1'b1 || bus.w_load_fault_o !== 1'b0) begin
                n_err++;
                $display("FAIL tmo_stall cycle %0d: got stall=%b fault=%b want 1/0", w,
                         bus.w_stall_o, bus.w_load_fault_o);
            end
            tick();
        end
        n_cmp++;
        if (bus.w_load_fault_o !== 1'b1 || bus.w_stall_o !== 1'b0 ||
            obs() !== expect_out(1'b0, m_rd, m_val) || bus.wb_state !== WB_IDLE) begin
            n_err++;
            $display("FAIL tmo_fault: got fault=%b stall=%b out=%h want 1/0/%h", bus.w_load_fault_o,
                     bus.w_stall_o, obs(), expect_out(1'b0, m_rd, m_val));
        end
        tick();
        n_cmp++;
        if (bus.w_load_fault_o !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_pulse_width: got fault=%b want 0", bus.w_load_fault_o);
        end
`else
        for (int w = 0; w < 20; w++) begin
            n_cmp++;
            if (bus.w_stall_o !== 1'b1 || bus.w_load_fault_o !== 1'b0) begin
                n_err++;
                $display("FAIL stall_persist cycle %0d: got stall=%b fault=%b want 1/0", w,
                         bus.w_stall_o, bus.w_load_fault_o);
            end
            tick();
        end
        bus.dm_data_l_i    = 32'h1357_9BDF;
        bus.dm_load_done_i = 1'b1;
        tick();
        bus.dm_load_done_i = 1'b0;
        n_cmp++;
        if (obs() !== expect_out(1'b1, 5'd20, 32'h1357_9BDF)) begin
            n_err++;
            $display("FAIL late_load: got %h want %h", obs(), expect_out(1'b1, 5'd20, 32'h1357_9BDF));
        end
        m_rd  = 5'd20;
        m_val = 32'h1357_9BDF;
`endif
        tick();
    endtask

    task automatic test_reset_mid_load();
        drive_alu(5'd9, 32'hAAAA_5555, 1'b1);
        drive_load(5'd3, 1'b1, 3'b010, 2'd0);
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 71'd0 || bus.w_stall_o !== 1'b0 || bus.wb_state !== WB_IDLE) begin
            n_err++;
            $display("FAIL reset_mid_load: got out=%h stall=%b state=%0d want zero/0/IDLE", obs(),
                     bus.w_stall_o, bus.wb_state);
        end
        tick();
        rst = 1'b0;
        bus.dm_data_l_i    = 32'h7777_7777;
        bus.dm_load_done_i = 1'b1;
        tick();
        bus.dm_load_done_i = 1'b0;
        n_cmp++;
        if (obs() !== 71'd0 || bus.w_stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL done_after_reset: got out=%h stall=%b want zero/0", obs(), bus.w_stall_o);
        end
        drive_alu(5'd11, 32'h1111_2222, 1'b1);
        drive_load(5'd12, 1'b1, 3'b010, 2'd0);
        rst                = 1'b1;
        bus.dm_data_l_i    = 32'h3333_4444;
        bus.dm_load_done_i = 1'b1;
        tick();
        rst                = 1'b0;
        bus.dm_load_done_i = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== 71'd0 || bus.wb_state !== WB_IDLE) begin
            n_err++;
            $display("FAIL reset_with_done: got out=%h state=%0d want zero/IDLE", obs(), bus.wb_state);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alu();
        test_load_align();
        test_done_in_idle();
        test_random();
        test_timeout();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
